// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp - multi-cycle data-memory responder for the MEM stage.
//
// Serves one load or store at a time from a word-addressed data array after a
// fixed access latency. While a request is in flight a combinational stall
// freezes the pipeline; load data is returned, registered, in the cycle the
// stall drops (DONE).
//
// Optional feature macro: DMEM_POSTED_WR_EN
//   When defined, stores are posted into a 1-entry write buffer without
//   stalling, and drain into the array on the following clock edge.
//
// Parameters:
//   DEPTH    words in the data array (power of two, <= 65536)
//   LATENCY  wait cycles per access (1..15)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   mem_to_reg  load request
//   reg_to_mem  store request (wins when both request bits are high)
//   addr        word address
//   wr_data     store data
//   rd_data     load data, valid while rd_valid=1
//   rd_valid    one-cycle load-complete strobe
//   stall       pipeline freeze, combinational
//   addr_err    one-cycle out-of-range strobe
// -----------------------------------------------------------------------------
module dmem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg,
    input  logic        reg_to_mem,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        stall,
    output logic        addr_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, next_state;
    logic [3:0]      cnt;
    logic            cap_load;
    logic            cap_oor;
    logic [AW-1:0]   cap_idx;
    logic            err_q;
    logic            in_range;
    logic            start;
    logic            access;
    logic [15:0]     read_word;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [15:0]     wdata;

    logic [15:0]     mem [DEPTH];

    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign access   = (state == WAIT) && (cnt == 4'd0);

`ifdef DMEM_POSTED_WR_EN
    logic            post_store;
    logic            wbuf_valid;
    logic [AW-1:0]   wbuf_idx;
    logic [15:0]     wbuf_data;

    // Stores never enter the FSM; only a pure load starts a stalled access.
    assign post_store = rst && (state == IDLE) && reg_to_mem;
    assign start      = rst && (state == IDLE) && mem_to_reg && !reg_to_mem;

    // A load racing its own buffered store must see the newer data.
    assign read_word = (wbuf_valid && (wbuf_idx == cap_idx)) ? wbuf_data : mem[cap_idx];

    assign we       = wbuf_valid;
    assign waddr    = wbuf_idx;
    assign wdata    = wbuf_data;
    assign addr_err = err_q | (post_store & ~in_range);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbuf_valid <= 1'b0;
            wbuf_idx   <= '0;
            wbuf_data  <= '0;
        end else begin
            // Draining and refilling share an edge, so back-to-back stores chain.
            wbuf_valid <= post_store && in_range;
            if (post_store && in_range) begin
                wbuf_idx  <= addr[AW-1:0];
                wbuf_data <= wr_data;
            end
        end
    end
`else
    logic [15:0]     cap_data;

    // rst gating lets stall drop the moment reset asserts, even with a request held.
    assign start     = rst && (state == IDLE) && (mem_to_reg || reg_to_mem);
    assign read_word = mem[cap_idx];
    assign we        = access && !cap_load && !cap_oor;
    assign waddr     = cap_idx;
    assign wdata     = cap_data;
    assign addr_err  = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_data <= '0;
        end else if (start) begin
            cap_data <= wr_data;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves an
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 4'd0;
            cap_load <= 1'b0;
            cap_oor  <= 1'b0;
            cap_idx  <= '0;
            rd_data  <= 16'h0000;
            rd_valid <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err_q    <= 1'b0;
            if (start) begin
                cap_load <= mem_to_reg && !reg_to_mem;
                cap_oor  <= !in_range;
                cap_idx  <= addr[AW-1:0];
                cnt      <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // The access edge: results become visible in DONE.
            if (access) begin
                err_q <= cap_oor;
                if (cap_load) begin
                    rd_valid <= 1'b1;
                    rd_data  <= cap_oor ? 16'h0000 : read_word;
                end
            end
        end
    end

    // NOTE: the data array has no reset; its contents are undefined until
    // written, which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule
